// File: rtl/hls_ctrl_pkg.sv
// Shared register map, control/interrupt bit positions and AXI4-Lite FSM
// state encodings for the hls_ctrl_regs control slave.
package hls_ctrl_pkg;

    // Register index = addr[7:3]; each register occupies one 64-bit slot
    localparam int          REG_IDX_W = 5;
    localparam logic [4:0]  IDX_CTRL  = 5'd0;   // 0x00
    localparam logic [4:0]  IDX_GIE   = 5'd1;   // 0x08
    localparam logic [4:0]  IDX_IER   = 5'd2;   // 0x10
    localparam logic [4:0]  IDX_ISR   = 5'd3;   // 0x18
    localparam logic [4:0]  IDX_ARG0  = 5'd4;   // 0x20 + 8*i
    localparam int          MAX_ARGS  = 28;

    // CTRL register bit positions
    localparam int CTRL_START = 0;
    localparam int CTRL_DONE  = 1;
    localparam int CTRL_IDLE  = 2;
    localparam int CTRL_READY = 3;
    localparam int CTRL_AUTO  = 7;

    // IER / ISR bit positions
    localparam int IRQ_DONE  = 0;
    localparam int IRQ_READY = 1;

    typedef enum logic [1:0] {
        W_ADDR = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_ADDR = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // Register index selected by a control-bus address
    function automatic logic [REG_IDX_W-1:0] reg_idx(input logic [7:0] addr_lo);
        return addr_lo[7:3];
    endfunction

endpackage

// File: rtl/hls_ctrl_regs_arg.sv
// One 64-bit argument register with per-byte write strobes.
module hls_ctrl_regs_arg #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   q
);

    localparam int STRB_W = DATA_WIDTH / 8;

    // Merge the strobed bytes of a committed write into the register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            q <= '0;
        end else if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) q[b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/hls_ctrl_regs.sv
// AXI4-Lite control slave with the HLS block-control programming model:
// CTRL/GIE/IER/ISR plus NUM_ARGS 64-bit argument registers.
// Independent write (AW -> W -> B) and read (AR -> R) state machines.
module hls_ctrl_regs
    import hls_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,   // must exceed 8; only addr[7:3] decoded
    parameter int DATA_WIDTH = 64,
    parameter int NUM_ARGS   = 4
) (
    input  logic                                 ap_clk,
    input  logic                                 ap_rst_n,
    input  logic                                 s_axi_control_AWVALID,
    output logic                                 s_axi_control_AWREADY,
    input  logic [ADDR_WIDTH-1:0]                s_axi_control_AWADDR,
    input  logic                                 s_axi_control_WVALID,
    output logic                                 s_axi_control_WREADY,
    input  logic [DATA_WIDTH-1:0]                s_axi_control_WDATA,
    input  logic [DATA_WIDTH/8-1:0]              s_axi_control_WSTRB,
    output logic                                 s_axi_control_BVALID,
    input  logic                                 s_axi_control_BREADY,
    output logic [1:0]                           s_axi_control_BRESP,
    input  logic                                 s_axi_control_ARVALID,
    output logic                                 s_axi_control_ARREADY,
    input  logic [ADDR_WIDTH-1:0]                s_axi_control_ARADDR,
    output logic                                 s_axi_control_RVALID,
    input  logic                                 s_axi_control_RREADY,
    output logic [DATA_WIDTH-1:0]                s_axi_control_RDATA,
    output logic [1:0]                           s_axi_control_RRESP,
    output logic                                 ap_start,
    input  logic                                 ap_done,
    input  logic                                 ap_ready,
    input  logic                                 ap_idle,
    output logic [NUM_ARGS-1:0][DATA_WIDTH-1:0]  args,
    output logic                                 interrupt
);

    localparam int STRB_W = DATA_WIDTH / 8;

    wr_state_e             wstate, wstate_nxt;
    rd_state_e             rstate, rstate_nxt;
    logic                  rst_done;
    logic [REG_IDX_W-1:0]  waddr_idx;
    logic [REG_IDX_W-1:0]  raddr_idx;
    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                  wr_ctrl, wr_gie, wr_ier, wr_isr;
    logic                  rd_ctrl;
    logic [NUM_ARGS-1:0]   arg_we;
    logic [DATA_WIDTH-1:0] rd_mux;

    logic                  auto_restart_q;
    logic                  done_q;
    logic                  gie_q;
    logic [1:0]            ier_q;
    logic [1:0]            isr_q;
    logic [1:0]            irq_evt;
    logic [1:0]            isr_tgl;

    // Address bits outside [7:3] are deliberately ignored (aliasing)
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_control_AWADDR[ADDR_WIDTH-1:8], s_axi_control_AWADDR[2:0],
                                s_axi_control_ARADDR[ADDR_WIDTH-1:8], s_axi_control_ARADDR[2:0]};

    assign aw_hs = s_axi_control_AWVALID && s_axi_control_AWREADY;
    assign w_hs  = s_axi_control_WVALID  && s_axi_control_WREADY;
    assign b_hs  = s_axi_control_BVALID  && s_axi_control_BREADY;
    assign ar_hs = s_axi_control_ARVALID && s_axi_control_ARREADY;
    assign r_hs  = s_axi_control_RVALID  && s_axi_control_RREADY;

    assign raddr_idx = reg_idx(s_axi_control_ARADDR[7:0]);

    assign s_axi_control_BRESP = 2'b00;
    assign s_axi_control_RRESP = 2'b00;

    // Hold address-channel ready low until the first edge after reset release
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) rst_done <= 1'b0;
        else           rst_done <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------

    // Write FSM state register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) wstate <= W_ADDR;
        else           wstate <= wstate_nxt;
    end

    // Write FSM next state: address, then data, then response
    always_comb begin
        wstate_nxt = wstate;
        case (wstate)
            W_ADDR:  if (aw_hs) wstate_nxt = W_DATA;
            W_DATA:  if (w_hs)  wstate_nxt = W_RESP;
            W_RESP:  if (b_hs)  wstate_nxt = W_ADDR;
            default:            wstate_nxt = W_ADDR;
        endcase
    end

    // Write FSM outputs: one channel ready per state
    always_comb begin
        s_axi_control_AWREADY = 1'b0;
        s_axi_control_WREADY  = 1'b0;
        s_axi_control_BVALID  = 1'b0;
        case (wstate)
            W_ADDR:  s_axi_control_AWREADY = rst_done;
            W_DATA:  s_axi_control_WREADY  = 1'b1;
            W_RESP:  s_axi_control_BVALID  = 1'b1;
            default: ;
        endcase
    end

    // Latch the register index of the accepted write address
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)  waddr_idx <= '0;
        else if (aw_hs) waddr_idx <= reg_idx(s_axi_control_AWADDR[7:0]);
    end

    // Control registers only look at the low byte lane
    assign wr_ctrl = w_hs && s_axi_control_WSTRB[0] && (waddr_idx == IDX_CTRL);
    assign wr_gie  = w_hs && s_axi_control_WSTRB[0] && (waddr_idx == IDX_GIE);
    assign wr_ier  = w_hs && s_axi_control_WSTRB[0] && (waddr_idx == IDX_IER);
    assign wr_isr  = w_hs && s_axi_control_WSTRB[0] && (waddr_idx == IDX_ISR);

    // Argument registers, one instance per slot
    for (genvar i = 0; i < NUM_ARGS; i++) begin : g_arg
        assign arg_we[i] = w_hs && (waddr_idx == REG_IDX_W'(IDX_ARG0 + i));

        hls_ctrl_regs_arg #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_arg (
            .ap_clk   (ap_clk),
            .ap_rst_n (ap_rst_n),
            .we       (arg_we[i]),
            .wstrb    (s_axi_control_WSTRB),
            .wdata    (s_axi_control_WDATA),
            .q        (args[i])
        );
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------

    // Read FSM state register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) rstate <= R_ADDR;
        else           rstate <= rstate_nxt;
    end

    // Read FSM next state: address, then data until RREADY
    always_comb begin
        rstate_nxt = rstate;
        case (rstate)
            R_ADDR:  if (ar_hs) rstate_nxt = R_DATA;
            R_DATA:  if (r_hs)  rstate_nxt = R_ADDR;
            default:            rstate_nxt = R_ADDR;
        endcase
    end

    // Read FSM outputs
    always_comb begin
        s_axi_control_ARREADY = (rstate == R_ADDR) && rst_done;
        s_axi_control_RVALID  = (rstate == R_DATA);
    end

    // Read data mux on the incoming address; unmapped slots read zero
    always_comb begin
        rd_mux = '0;
        case (raddr_idx)
            IDX_CTRL: begin
                rd_mux[CTRL_START] = ap_start;
                rd_mux[CTRL_DONE]  = done_q;
                rd_mux[CTRL_IDLE]  = ap_idle;
                rd_mux[CTRL_READY] = ap_ready;
                rd_mux[CTRL_AUTO]  = auto_restart_q;
            end
            IDX_GIE: rd_mux[0]   = gie_q;
            IDX_IER: rd_mux[1:0] = ier_q;
            IDX_ISR: rd_mux[1:0] = isr_q;
            default: begin
                for (int i = 0; i < NUM_ARGS; i++) begin
                    if (raddr_idx == REG_IDX_W'(IDX_ARG0 + i)) rd_mux = args[i];
                end
            end
        endcase
    end

    // Capture read data at AR accept and hold it until RREADY
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)  s_axi_control_RDATA <= '0;
        else if (ar_hs) s_axi_control_RDATA <= rd_mux;
    end

    assign rd_ctrl = ar_hs && (raddr_idx == IDX_CTRL);

    // ------------------------------------------------------------------
    // Block control and interrupts
    // ------------------------------------------------------------------

    // ap_start: software sets, core ready clears unless auto-restarting
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)                              ap_start <= 1'b0;
        else if (wr_ctrl && s_axi_control_WDATA[CTRL_START]) ap_start <= 1'b1;
        else if (ap_ready && !auto_restart_q)       ap_start <= 1'b0;
    end

    // auto_restart, GIE and IER are plain software-written bits
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            auto_restart_q <= 1'b0;
            gie_q          <= 1'b0;
            ier_q          <= '0;
        end else begin
            if (wr_ctrl) auto_restart_q <= s_axi_control_WDATA[CTRL_AUTO];
            if (wr_gie)  gie_q          <= s_axi_control_WDATA[0];
            if (wr_ier)  ier_q          <= s_axi_control_WDATA[1:0];
        end
    end

    // Sticky done: a new pulse beats a concurrent clear-on-read
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)    done_q <= 1'b0;
        else if (ap_done) done_q <= 1'b1;
        else if (rd_ctrl) done_q <= 1'b0;
    end

    assign irq_evt = {ap_ready, ap_done} & ier_q;
    assign isr_tgl = wr_isr ? s_axi_control_WDATA[1:0] : 2'b00;

    // ISR: enabled events set, software writes toggle, set wins a collision
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) isr_q <= '0;
        else           isr_q <= irq_evt | (isr_q ^ isr_tgl);
    end

    // Registered level interrupt
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) interrupt <= 1'b0;
        else           interrupt <= gie_q & (|isr_q);
    end

endmodule
